// File: rtl/queens_pkg.sv
// Shared types and defaults for the N-queens board checker.
package queens_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_ONEHOT = 2'd1,
    ERR_ROW    = 2'd2,
    ERR_DIAG   = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    PAIR   = 2'd2,
    DONE_S = 2'd3
  } state_t;

endpackage

// File: rtl/queens_board_checker_if.sv
// Request/result bundle between a board producer and the queens board checker.
interface queens_board_checker_if
  import queens_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int IW = $clog2(N)
);
  logic           START;
  logic [N*N-1:0] board;
  logic           READY;
  logic           DONE;
  logic           VALID;
  logic [1:0]     ERR_CODE;
  logic [IW-1:0]  ERR_COL_A;
  logic [IW-1:0]  ERR_COL_B;

  modport master (
    output START, board,
    input  READY, DONE, VALID, ERR_CODE, ERR_COL_A, ERR_COL_B
  );

  modport slave (
    input  START, board,
    output READY, DONE, VALID, ERR_CODE, ERR_COL_A, ERR_COL_B
  );
endinterface

// File: rtl/queens_onehot_enc.sv
// Combinational one-hot check and row-index encoder for a single board column.
module queens_onehot_enc #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  col_i,
  output logic          onehot_o,
  output logic [IW-1:0] row_o
);

  always_comb begin
    row_o = '0;
    for (int r = 0; r < N; r++) begin
      if (col_i[r]) begin
        row_o = row_o | IW'(r);
      end
    end
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    onehot_o = (col_i != '0) && ((col_i & (col_i - N'(1))) == '0);
  end

endmodule

// File: rtl/queens_board_checker.sv
// Sequential N-queens board validator: one-hot pass over columns, then all column pairs.
module queens_board_checker
  import queens_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int IW = $clog2(N)
) (
  input logic                   clk,
  input logic                   rst,
  queens_board_checker_if.slave bus
);

  state_t         state_q, state_d;
  logic [N*N-1:0] snap_q, snap_d;
  logic [IW-1:0]  col_q, col_d;
  logic [IW-1:0]  i_q, i_d;
  logic [IW-1:0]  j_q, j_d;
  logic           valid_q, valid_d;
  err_code_t      err_q, err_d;
  logic [IW-1:0]  erra_q, erra_d;
  logic [IW-1:0]  errb_q, errb_d;

  logic [IW-1:0]  rowidx_q [N];
  logic           rowidx_we;

  logic [N-1:0]   snap_cols [N];
  logic [N-1:0]   col_word;
  logic           enc_onehot;
  logic [IW-1:0]  enc_row;

  logic [IW:0]    ri_ext, rj_ext, row_dist, col_dist;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cols
      assign snap_cols[gi] = snap_q[gi*N +: N];

      always_ff @(posedge clk) begin
        if (rst) begin
          rowidx_q[gi] <= '0;
        end else if (rowidx_we && (col_q == IW'(gi))) begin
          rowidx_q[gi] <= enc_row;
        end
      end
    end
  endgenerate

  assign col_word = snap_cols[col_q];

  queens_onehot_enc #(.N(N), .IW(IW)) u_enc (
    .col_i    (col_word),
    .onehot_o (enc_onehot),
    .row_o    (enc_row)
  );

  // Row distance as an unsigned magnitude, one bit wider than an index.
  assign ri_ext   = {1'b0, rowidx_q[i_q]};
  assign rj_ext   = {1'b0, rowidx_q[j_q]};
  assign row_dist = (ri_ext >= rj_ext) ? (ri_ext - rj_ext) : (rj_ext - ri_ext);
  assign col_dist = {1'b0, j_q} - {1'b0, i_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      col_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= ERR_NONE;
      erra_q  <= '0;
      errb_q  <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      col_q   <= col_d;
      i_q     <= i_d;
      j_q     <= j_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      erra_q  <= erra_d;
      errb_q  <= errb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    col_d     = col_q;
    i_d       = i_q;
    j_d       = j_q;
    valid_d   = valid_q;
    err_d     = err_q;
    erra_d    = erra_q;
    errb_d    = errb_q;
    rowidx_we = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          snap_d  = bus.board;
          col_d   = '0;
          valid_d = 1'b0;
          err_d   = ERR_NONE;
          erra_d  = '0;
          errb_d  = '0;
          state_d = ENCODE;
        end
      end

      ENCODE: begin
        if (!enc_onehot) begin
          err_d   = ERR_ONEHOT;
          erra_d  = col_q;
          errb_d  = col_q;
          valid_d = 1'b0;
          state_d = DONE_S;
        end else begin
          rowidx_we = 1'b1;
          if (col_q == IW'(N-1)) begin
            i_d     = '0;
            j_d     = IW'(1);
            state_d = PAIR;
          end else begin
            col_d = col_q + IW'(1);
          end
        end
      end

      PAIR: begin
        if (rowidx_q[i_q] == rowidx_q[j_q]) begin
          err_d   = ERR_ROW;
          erra_d  = i_q;
          errb_d  = j_q;
          state_d = DONE_S;
        end else if (row_dist == col_dist) begin
          err_d   = ERR_DIAG;
          erra_d  = i_q;
          errb_d  = j_q;
          state_d = DONE_S;
        end else if (j_q == IW'(N-1)) begin
          if (i_q == IW'(N-2)) begin
            valid_d = 1'b1;
            err_d   = ERR_NONE;
            state_d = DONE_S;
          end else begin
            i_d = i_q + IW'(1);
            j_d = i_q + IW'(2);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end

      DONE_S: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.READY     = (state_q == IDLE);
  assign bus.DONE      = (state_q == DONE_S);
  assign bus.VALID     = valid_q;
  assign bus.ERR_CODE  = err_q;
  assign bus.ERR_COL_A = erra_q;
  assign bus.ERR_COL_B = errb_q;

endmodule
